baseline_correlator: RTL and testbench
======================================

BASELINE_CORRELATOR -- requirements
Module: baseline_correlator

Interface
REQ-001 Parameter NUM_ANT, default 24, number of antenna bit lanes on the input bus.
REQ-002 Parameter ANT_A, default 0, index of the first antenna of the baseline.
REQ-003 Parameter ANT_B, default 1, index of the second antenna of the baseline.
REQ-004 Parameter ACC_LOG2, default 12, integration window of N = 2^ACC_LOG2 valid samples.
REQ-005 clk16  in  1  sample clock; the block SHALL use one clock, and all logic SHALL run on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 data_i  in  NUM_ANT  per-antenna I sign bits from the radio stage.
REQ-008 data_q  in  NUM_ANT  per-antenna Q sign bits.
REQ-009 in_valid  in  1  data_i/data_q hold a sample this cycle.
REQ-010 clear  in  1  synchronous restart of the current window.
REQ-011 out_re, out_im  out  ACC_LOG2+3 each  signed visibility result.
REQ-012 out_valid / out_ready  out / in  1 each  result handshake.
REQ-013 overrun  out  1  sticky flag, set when a result is dropped.

Function
REQ-014 Bit 1 SHALL map to +1 and bit 0 to -1; the per-sample product is a*conj(b).
- re = ia*ib + qa*qb
- im = qa*ib - ia*qb
REQ-015 Four agreement counters SHALL each count, over valid samples, one of: ia==ib, qa==qb, qa==ib, ia==qb.
REQ-016 At window end the block SHALL compute:
- re = 2*(c_ii + c_qq) - 2N
- im = 2*(c_qi - c_iq)
- exact, with no saturation; the range is [-2N, 2N].
REQ-017 Samples with in_valid=0 SHALL NOT be counted and SHALL NOT advance the sample counter.
REQ-018 Window end is the valid sample with sample counter = N-1. That sample SHALL be included.
REQ-019 At window end, all counters SHALL reset so that the next valid sample starts a new window with no gap.
REQ-020 The result SHALL appear on out_re/out_im with out_valid=1 on the cycle after the window-end edge (latency 1).
REQ-021 out_re, out_im and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 The result SHALL be consumed on a clock edge where out_valid and out_ready are both 1; out_valid SHALL then drop unless REQ-024 applies.
REQ-023 Window end while out_valid=1 and out_ready=0 SHALL drop the new result, keep the held result, and set overrun.
REQ-024 Window end on the same edge as a consume SHALL load the new result, keep out_valid=1, and SHALL NOT set overrun.
REQ-025 clear=1 SHALL zero the sample counter and agreement counters. It SHALL leave the output register, out_valid and overrun unchanged.
REQ-026 clear coincident with a window-end sample: clear SHALL win, and no result is produced.
REQ-027 overrun SHALL be cleared only by reset.

Reset
REQ-028 rst_n=0 SHALL asynchronously force the following to zero:
- out_re, out_im, out_valid, overrun
- all agreement counters and the sample counter
REQ-029 Reset mid-window SHALL discard the partial window; the first valid sample after release is sample 0.

Configuration
REQ-030 With macro CORR_OVERRUN_CNT_EN defined, the block SHALL provide an extra output port overrun_cnt[7:0].
- increments once per dropped result
- saturates at 255
- cleared only by reset
REQ-031 Without CORR_OVERRUN_CNT_EN, the port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-032 Package corr_pkg SHALL hold:
- the sign-bit mapping constants
- a function returning the output width ACC_LOG2+3
- the result struct type {re, im}
REQ-033 Sub-module corr_agree_counter SHALL implement one clearable, enable-gated agreement counter of width ACC_LOG2+1. It SHALL be instantiated four times.

Verification (ACC_LOG2=4, N=16)
REQ-034 Sign test: 16 valid samples of ia=ib=1, qa=qb=0 -> out_re=+32, out_im=0, one cycle after the 16th sample.
REQ-035 Real and imaginary tests:
- 16 samples of ia=1, qa=0, ib=0, qb=1 -> out_re=-32, out_im=0.
- 16 samples of ia=qa=1, ib=1, qb=0 -> out_re=0, out_im=+32.
REQ-036 Gaps and clear:
- 16 samples interleaved with in_valid=0 cycles -> same result as gap-free.
- clear at sample 7, then 16 samples -> result reflects only the last 16.
REQ-037 Backpressure: out_ready=0 across two windows -> first result held stable, overrun=1, second dropped. With CORR_OVERRUN_CNT_EN, overrun_cnt=1.
REQ-038 Simultaneous events:
- out_ready=1 on the window-end edge with a result pending -> new result loaded, out_valid stays 1, overrun=0.
- rst_n pulsed at sample 9 -> all outputs 0, next result counts only post-reset samples.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared constants, output-width helper and result type for the baseline correlator.
package corr_pkg;

    localparam logic SIGN_POS = 1'b1;  // sign bit 1 represents +1
    localparam logic SIGN_NEG = 1'b0;  // sign bit 0 represents -1

    localparam int RES_W_MAX = 32;

    function automatic int out_width(input int acc_log2);
        return acc_log2 + 3;
    endfunction

    typedef struct packed {
        logic [RES_W_MAX-1:0] re;
        logic [RES_W_MAX-1:0] im;
    } corr_result_t;

endpackage

// File: rtl/corr_agree_counter.sv
// One agreement counter: counts cycles where en and match are both high, zeroed by clear.
module corr_agree_counter #(
    parameter int WIDTH = 13
) (
    input  logic             clk16,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic             match,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && match) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/baseline_correlator.sv
// One-baseline 1-bit complex correlator with a held result register and overrun flag.
// Optional overrun_cnt[7:0] output is enabled by defining CORR_OVERRUN_CNT_EN.
module baseline_correlator
    import corr_pkg::*;
#(
    parameter int NUM_ANT  = 24,
    parameter int ANT_A    = 0,
    parameter int ANT_B    = 1,
    parameter int ACC_LOG2 = 12
) (
    input  logic                                  clk16,
    input  logic                                  rst_n,
    input  logic [NUM_ANT-1:0]                    data_i,
    input  logic [NUM_ANT-1:0]                    data_q,
    input  logic                                  in_valid,
    input  logic                                  clear,
    output logic signed [out_width(ACC_LOG2)-1:0] out_re,
    output logic signed [out_width(ACC_LOG2)-1:0] out_im,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  overrun
`ifdef CORR_OVERRUN_CNT_EN
    ,
    output logic [7:0]                            overrun_cnt
`endif
);

    localparam int W  = out_width(ACC_LOG2);
    localparam int CW = ACC_LOG2 + 1;
    localparam int N2 = 2 ** (ACC_LOG2 + 1);
    localparam logic [ACC_LOG2-1:0] SAMP_LAST = '1;

    logic [3:0]          match;
    logic [CW-1:0]       cnt [4];
    logic [CW-1:0]       tot [4];
    logic [ACC_LOG2-1:0] samp_d, samp_q;
    logic                win_end;
    logic                consume;
    logic                drop;
    logic [W-2:0]        sum_r, diff_i;
    logic [W-1:0]        re_u, im_u;
    corr_result_t        res_d, res_q;
    logic                out_valid_d, out_valid_q;
    logic                overrun_d, overrun_q;
    logic                unused_bits;

    // match order: ii, qq, qi, iq
    assign match[0] = data_i[ANT_A] ~^ data_i[ANT_B];
    assign match[1] = data_q[ANT_A] ~^ data_q[ANT_B];
    assign match[2] = data_q[ANT_A] ~^ data_i[ANT_B];
    assign match[3] = data_i[ANT_A] ~^ data_q[ANT_B];

    assign win_end = in_valid && !clear && (samp_q == SAMP_LAST);
    assign consume = out_valid_q && out_ready;
    assign drop    = win_end && out_valid_q && !out_ready;

    for (genvar k = 0; k < 4; k++) begin : g_agree
        corr_agree_counter #(.WIDTH(CW)) u_cnt (
            .clk16 (clk16),
            .rst_n (rst_n),
            .clear (clear | win_end),
            .en    (in_valid),
            .match (match[k]),
            .count (cnt[k])
        );
        // the window-end sample is folded in here since the counters restart on that edge
        assign tot[k] = cnt[k] + CW'(match[k]);
    end

    assign sum_r  = (W-1)'(tot[0]) + (W-1)'(tot[1]);
    assign diff_i = (W-1)'(tot[2]) - (W-1)'(tot[3]);
    assign re_u   = {sum_r, 1'b0} - W'(N2);
    assign im_u   = {diff_i, 1'b0};

    always_comb begin
        samp_d      = samp_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (clear || win_end) begin
            samp_d = '0;
        end else if (in_valid) begin
            samp_d = samp_q + ACC_LOG2'(1);
        end

        if (consume) begin
            out_valid_d = 1'b0;
        end

        if (win_end) begin
            if (!out_valid_q || out_ready) begin
                res_d.re    = {{(RES_W_MAX-W){re_u[W-1]}}, re_u};
                res_d.im    = {{(RES_W_MAX-W){im_u[W-1]}}, im_u};
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            samp_q      <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            samp_q      <= samp_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_re    = res_q.re[W-1:0];
    assign out_im    = res_q.im[W-1:0];
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

`ifdef CORR_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_d, overrun_cnt_q;

    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        if (drop && (overrun_cnt_q != 8'hFF)) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            overrun_cnt_q <= '0;
        end else begin
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
    assign unused_bits = ^{data_i, data_q, res_q.re[RES_W_MAX-1:W], res_q.im[RES_W_MAX-1:W]};
`else
    assign unused_bits = ^{data_i, data_q, drop, res_q.re[RES_W_MAX-1:W], res_q.im[RES_W_MAX-1:W]};
`endif

endmodule

// File: tb/tb_baseline_correlator.sv
// Directed bench for baseline_correlator with ACC_LOG2=4 (N=16) and a +/-1 product model.
module tb_baseline_correlator;

    localparam int NUM_ANT  = 24;
    localparam int ANT_A    = 0;
    localparam int ANT_B    = 1;
    localparam int ACC_LOG2 = 4;
    localparam int N        = 16;
    localparam int W        = ACC_LOG2 + 3;

    typedef struct {
        int re;
        int im;
    } exp_t;

    logic                clk16 = 1'b0;
    logic                rst_n;
    logic [NUM_ANT-1:0]  data_i, data_q;
    logic                in_valid, clear, out_ready;
    logic signed [W-1:0] out_re, out_im;
    logic                out_valid, overrun;
`ifdef CORR_OVERRUN_CNT_EN
    logic [7:0]          overrun_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t held;
    int   m_cnt, m_re, m_im;

    baseline_correlator #(
        .NUM_ANT (NUM_ANT),
        .ANT_A   (ANT_A),
        .ANT_B   (ANT_B),
        .ACC_LOG2(ACC_LOG2)
    ) dut (
        .clk16    (clk16),
        .rst_n    (rst_n),
        .data_i   (data_i),
        .data_q   (data_q),
        .in_valid (in_valid),
        .clear    (clear),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun)
`ifdef CORR_OVERRUN_CNT_EN
        ,
        .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk16 = ~clk16;

    function automatic int sgn(input logic b);
        return b ? 1 : -1;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_re  = 0;
        m_im  = 0;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle at the negedge, update the model at the posedge, return at the next negedge.
    task automatic step(input logic v, input logic ia, input logic qa, input logic ib,
                        input logic qb, input logic clr);
        logic [NUM_ANT-1:0] di, dq;
        exp_t e;
        di = NUM_ANT'($urandom);
        dq = NUM_ANT'($urandom);
        di[ANT_A] = ia;
        di[ANT_B] = ib;
        dq[ANT_A] = qa;
        dq[ANT_B] = qb;
        data_i   = di;
        data_q   = dq;
        in_valid = v;
        clear    = clr;
        @(posedge clk16);
        if (clr) begin
            model_reset();
        end else if (v) begin
            m_re += sgn(ia) * sgn(ib) + sgn(qa) * sgn(qb);
            m_im += sgn(qa) * sgn(ib) - sgn(ia) * sgn(qb);
            m_cnt++;
            if (m_cnt == N) begin
                e.re = m_re;
                e.im = m_im;
                sb.push_back(e);
                model_reset();
            end
        end
        @(negedge clk16);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic rstep(input logic v);
        step(v, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic expect_front(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
            return;
        end
        e = sb[0];
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_re"}, 32'(out_re), e.re);
        chk({tag, "_im"}, 32'(out_im), e.im);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        chk({tag, "_drop"}, 32'(out_valid), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        data_i    = '0;
        data_q    = '0;
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk16);
        chk("rst_re", 32'(out_re), 0);
        chk("rst_im", 32'(out_im), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        @(negedge clk16);

        // sign test with latency check
        for (int i = 0; i < N - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("sign_early", 32'(out_valid), 0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_front("sign");
        chk("sign_spec_re", 32'(out_re), 32);
        consume("sign");

        for (int i = 0; i < N; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_front("real");
        chk("real_spec_re", 32'(out_re), -32);
        consume("real");

        for (int i = 0; i < N; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_front("imag");
        chk("imag_spec_im", 32'(out_im), 32);
        consume("imag");

        // gaps between valid samples
        for (int i = 0; i < N; i++) begin
            rstep(1'b1);
            repeat (i % 3) rstep(1'b0);
        end
        expect_front("gaps");
        consume("gaps");

        // clear at sample 7
        for (int i = 0; i < 7; i++) rstep(1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) rstep(1'b1);
        expect_front("clear7");
        consume("clear7");

        // clear coincident with window end produces nothing
        for (int i = 0; i < N - 1; i++) rstep(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("clr_end_valid", 32'(out_valid), 0);
        for (int i = 0; i < N; i++) rstep(1'b1);
        expect_front("clr_end_next");
        consume("clr_end_next");

        // consume on the same edge as a new window end
        for (int i = 0; i < N; i++) rstep(1'b1);
        expect_front("sim_first");
        for (int i = 0; i < N - 1; i++) rstep(1'b1);
        out_ready = 1'b1;
        rstep(1'b1);
        out_ready = 1'b0;
        void'(sb.pop_front());
        expect_front("sim_second");
        chk("sim_overrun", 32'(overrun), 0);
        consume("sim_second");

        // backpressure across two windows
        for (int i = 0; i < N; i++) rstep(1'b1);
        expect_front("bp_first");
        held = sb[0];
        for (int i = 0; i < N; i++) begin
            rstep(1'b1);
            if (i % 5 == 4) chk("bp_hold_re", 32'(out_re), held.re);
        end
        expect_front("bp_after");
        chk("bp_overrun", 32'(overrun), 1);
`ifdef CORR_OVERRUN_CNT_EN
        chk("bp_ocnt", 32'(overrun_cnt), 1);
`endif
        consume("bp_first");
        void'(sb.pop_front());
        chk("bp_sticky", 32'(overrun), 1);
        for (int i = 0; i < N; i++) rstep(1'b1);
        expect_front("bp_recover");

        // reset at sample 9 with a result pending
        for (int i = 0; i < 9; i++) rstep(1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_re", 32'(out_re), 0);
        chk("mrst_im", 32'(out_im), 0);
        chk("mrst_valid", 32'(out_valid), 0);
        chk("mrst_overrun", 32'(overrun), 0);
`ifdef CORR_OVERRUN_CNT_EN
        chk("mrst_ocnt", 32'(overrun_cnt), 0);
`endif
        sb.delete();
        model_reset();
        @(negedge clk16);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) rstep(1'b1);
        expect_front("post_rst");
        consume("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
